// File: rtl/mem_io_ctrl.sv
// Memory and I/O controller for the simple RISC CPU: wait-state FSM in front of
// on-chip RAM, a switch/LED port and an unmapped region with a sticky error flag.
module mem_io_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 9,
    parameter int                RAM_AW      = 8,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] IO_ADDR     = 'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out,
    output logic              err_bad_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_ILL   = 2'b11
    } cmd_e;

    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    cmd_e                cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          led_q, led_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   ram [RAM_DEPTH];

    cmd_e                acc_cmd;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                commit;
    logic                in_ram;
    logic                in_io;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_idx;

    // The access operands come straight from the bus on the acceptance edge
    // (needed when WAIT_STATES=0) and from the latched copy afterwards.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        acc_cmd   = cmd_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                acc_cmd   = cmd_e'(mem_cmd);
                acc_addr  = mem_addr;
                acc_wdata = write_data;
                if (cmd_e'(mem_cmd) == CMD_READ || cmd_e'(mem_cmd) == CMD_WRITE) begin
                    cmd_d   = cmd_e'(mem_cmd);
                    addr_d  = mem_addr;
                    wdata_d = write_data;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The access takes effect on the edge that enters DONE.
    assign commit  = (state_d == S_DONE) && (state_q != S_DONE);
    assign in_ram  = 32'(acc_addr) < RAM_DEPTH;
    assign in_io   = !in_ram && (acc_addr == IO_ADDR);
    assign ram_idx = acc_addr[RAM_AW-1:0];

    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        if (commit) begin
            if (acc_cmd == CMD_READ) begin
                if (in_ram) begin
                    rdata_d = ram[ram_idx];
                end else if (in_io) begin
                    rdata_d = {{(DATA_W-8){1'b0}}, sw_in};
                end else begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end else begin
                if (in_ram) begin
                    ram_we = 1'b1;
                end else if (in_io) begin
                    led_d = acc_wdata[7:0];
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            led_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto plain memory; its contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= acc_wdata;
        end
    end

    assign mem_ready    = (state_q == S_DONE);
    assign read_data    = rdata_q;
    assign led_out      = led_q;
    assign err_bad_addr = err_q;

endmodule
